// File: rtl/config_cb_chain_if.sv
// config_cb_chain_if: program-chain and switch-control signals of one connection block
interface config_cb_chain_if #(
    parameter int CFG_BITS = 48,
    parameter int LANES    = 1
);
    logic                prgm_b;
    logic                cb_prgm_b;
    logic                cb_prgm_b_in;
    logic [LANES-1:0]    bit_in;
    logic [CFG_BITS-1:0] cfg_out;
    logic                cfg_valid;
    logic                cfg_err;
    logic                cb_prgm_b_out;
    modport master (
        output prgm_b, cb_prgm_b, cb_prgm_b_in, bit_in,
        input  cfg_out, cfg_valid, cfg_err, cb_prgm_b_out
    );
    modport slave (
        input  prgm_b, cb_prgm_b, cb_prgm_b_in, bit_in,
        output cfg_out, cfg_valid, cfg_err, cb_prgm_b_out
    );
endinterface

// File: rtl/config_cb_chain.sv
// config_cb_chain: daisy-chained serial config loader with atomic commit and optional parity
module config_cb_chain #(
    parameter int CFG_BITS  = 48,
    parameter int LANES     = 1,
    parameter int PARITY_EN = 0
) (
    input logic clk,
    input logic reset,
    config_cb_chain_if.slave bus
);
    localparam int BEATS = CFG_BITS / LANES;
    localparam int NB    = BEATS + PARITY_EN;
    localparam int CW    = $clog2(NB + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
    state_t              state;
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] shifted;
    logic [CW-1:0]       count;
    logic                en;
    logic                last;
    logic                par_ok;
    assign en      = ~bus.prgm_b & bus.cb_prgm_b & bus.cb_prgm_b_in;
    assign shifted = (shadow << LANES) | CFG_BITS'(bus.bit_in);
    assign last    = count == CW'(BEATS - 1);
    assign par_ok  = ~(^shadow ^ bus.bit_in[0]);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            shadow            <= '0;
            count             <= '0;
            bus.cfg_out       <= '0;
            bus.cfg_valid     <= 1'b0;
            bus.cfg_err       <= 1'b0;
            bus.cb_prgm_b_out <= 1'b0;
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    if (bus.prgm_b) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (en) begin
                        shadow <= shifted;
                        count  <= count + 1'b1;
                        if (state == IDLE) bus.cfg_err <= 1'b0;
                        // the final data beat is folded into the commit on the same edge
                        if (last && PARITY_EN != 0) begin
                            state <= PARITY;
                        end else if (last) begin
                            state             <= DONE;
                            bus.cfg_out       <= shifted;
                            bus.cfg_valid     <= 1'b1;
                            bus.cb_prgm_b_out <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                PARITY: begin
                    if (bus.prgm_b) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (en) begin
                        state             <= DONE;
                        count             <= count + 1'b1;
                        bus.cb_prgm_b_out <= 1'b1;
                        if (par_ok) begin
                            bus.cfg_out   <= shadow;
                            bus.cfg_valid <= 1'b1;
                        end else begin
                            bus.cfg_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.prgm_b) begin
                        state             <= IDLE;
                        count             <= '0;
                        bus.cb_prgm_b_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_cb_chain.sv
// tb_config_cb_chain: scoreboard bench for three loader configurations sharing one program chain
module tb_config_cb_chain;
    typedef struct {
        int          d;
        logic [47:0] cfg;
        logic        err;
        int          at;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset;
    logic        prgm_b;
    logic        chain;
    logic [2:0]  cb;
    logic [3:0]  bits;
    int          cyc;
    int          n_chk;
    int          n_fail;
    exp_t        q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    config_cb_chain_if #(.CFG_BITS(48), .LANES(1)) i0 ();
    config_cb_chain_if #(.CFG_BITS(48), .LANES(4)) i1 ();
    config_cb_chain_if #(.CFG_BITS(48), .LANES(1)) i2 ();
    assign i0.prgm_b = prgm_b;
    assign i1.prgm_b = prgm_b;
    assign i2.prgm_b = prgm_b;
    assign i0.cb_prgm_b = cb[0];
    assign i1.cb_prgm_b = cb[1];
    assign i2.cb_prgm_b = cb[2];
    assign i0.cb_prgm_b_in = chain;
    assign i1.cb_prgm_b_in = chain;
    assign i2.cb_prgm_b_in = chain;
    assign i0.bit_in = bits[0];
    assign i1.bit_in = bits;
    assign i2.bit_in = bits[0];
    config_cb_chain #(.CFG_BITS(48), .LANES(1), .PARITY_EN(0)) u0 (.clk(clk), .reset(reset), .bus(i0));
    config_cb_chain #(.CFG_BITS(48), .LANES(4), .PARITY_EN(0)) u1 (.clk(clk), .reset(reset), .bus(i1));
    config_cb_chain #(.CFG_BITS(48), .LANES(1), .PARITY_EN(1)) u2 (.clk(clk), .reset(reset), .bus(i2));
    function automatic logic [47:0] out_cfg(input int d);
        return d == 0 ? i0.cfg_out : d == 1 ? i1.cfg_out : i2.cfg_out;
    endfunction
    function automatic logic out_cb(input int d);
        return d == 0 ? i0.cb_prgm_b_out : d == 1 ? i1.cb_prgm_b_out : i2.cb_prgm_b_out;
    endfunction
    function automatic logic out_valid(input int d);
        return d == 0 ? i0.cfg_valid : d == 1 ? i1.cfg_valid : i2.cfg_valid;
    endfunction
    function automatic logic out_err(input int d);
        return d == 0 ? i0.cfg_err : d == 1 ? i1.cfg_err : i2.cfg_err;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    // every rising cb_prgm_b_out must match the oldest expected commit
    logic [2:0] prev = 3'b000;
    always @(negedge clk) begin
        logic [2:0] now;
        exp_t e;
        now = {i2.cb_prgm_b_out, i1.cb_prgm_b_out, i0.cb_prgm_b_out};
        for (int d = 0; d < 3; d++) begin
            if (now[d] && !prev[d]) begin
                if (q.size() == 0) begin
                    chk("unexpected_commit", 64'(d), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("commit_block", 64'(d), 64'(e.d));
                    chk("commit_cycle", 64'(cyc), 64'(e.at));
                    chk("commit_cfg_out", out_cfg(d), e.cfg);
                    chk("commit_cfg_valid", out_valid(d), 1);
                    chk("commit_cfg_err", out_err(d), e.err);
                end
            end
        end
        prev = now;
    end
    task automatic load(input int d, input logic [47:0] frame, input int par, input int gap_at,
                        input int abort_at, input logic [47:0] old_cfg, input logic [47:0] exp_cfg,
                        input logic exp_err);
        int lanes, n, edges;
        lanes = d == 1 ? 4 : 1;
        n = 48 / lanes;
        @(negedge clk);
        if (abort_at < 0) begin
            edges = n + (par >= 0 ? 1 : 0) + (gap_at >= 0 ? 5 : 0);
            q.push_back('{d, exp_cfg, exp_err, cyc + edges});
        end
        prgm_b = 1'b0;
        cb[d]  = 1'b1;
        chain  = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                prgm_b = 1'b1;
                @(negedge clk);
                chk("abort_cb_out", out_cb(d), 0);
                chk("abort_cfg_out", out_cfg(d), old_cfg);
                chk("abort_cfg_valid", out_valid(d), 1);
                cb[d] = 1'b0;
                return;
            end
            if (k == gap_at) begin
                chain = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    bits = {3'b000, ~frame[47-k]};
                    @(negedge clk);
                end
                chain = 1'b1;
            end
            if (k == n - 1) begin
                chk("pre_commit_cfg_out", out_cfg(d), old_cfg);
                chk("pre_commit_cb_out", out_cb(d), 0);
            end
            bits = lanes == 4 ? frame[47-4*k -: 4] : {3'b000, frame[47-k]};
            @(negedge clk);
        end
        if (par >= 0) begin
            bits = 4'(par);
            @(negedge clk);
        end
        prgm_b = 1'b1;
        @(negedge clk);
        chk("release_cb_out", out_cb(d), 0);
        cb[d] = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        reset  = 1'b1;
        prgm_b = 1'b1;
        chain  = 1'b0;
        cb     = 3'b000;
        bits   = 4'h0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_cfg_out", out_cfg(d), 0);
            chk("reset_cfg_valid", out_valid(d), 0);
        end
        chk("reset_cfg_err", out_err(0), 0);
        chk("reset_cb_out", out_cb(0), 0);
        reset = 1'b0;
        load(0, 48'hA5A5C3C30F0F, -1, -1, -1, 48'h0, 48'hA5A5C3C30F0F, 1'b0);
        load(1, 48'hA5A5C3C30F0F, -1, -1, -1, 48'h0, 48'hA5A5C3C30F0F, 1'b0);
        load(2, 48'h000000000001, 1, -1, -1, 48'h0, 48'h000000000001, 1'b0);
        load(2, 48'h000000000003, 1, -1, -1, 48'h000000000001, 48'h000000000001, 1'b1);
        chk("parity_fail_valid_sticky", out_valid(2), 1);
        load(0, 48'h123456789ABC, -1, 20, -1, 48'hA5A5C3C30F0F, 48'h123456789ABC, 1'b0);
        load(0, 48'hFFFF00000000, -1, -1, 30, 48'h123456789ABC, 48'h0, 1'b0);
        load(0, 48'h0F0F0F0F0F0F, -1, -1, -1, 48'h123456789ABC, 48'h0F0F0F0F0F0F, 1'b0);
        @(negedge clk);
        prgm_b = 1'b0;
        cb[0]  = 1'b1;
        chain  = 1'b1;
        bits   = 4'h1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_cfg_out", out_cfg(0), 0);
        chk("async_reset_cfg_valid", out_valid(0), 0);
        chk("async_reset_cfg_err", out_err(2), 0);
        chk("async_reset_cb_out", out_cb(0), 0);
        chk("async_reset_cfg_out_b2", out_cfg(2), 0);
        @(negedge clk);
        reset  = 1'b0;
        prgm_b = 1'b1;
        cb     = 3'b000;
        load(0, 48'hA5A5C3C30F0F, -1, -1, -1, 48'h0, 48'hA5A5C3C30F0F, 1'b0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
